// File: rtl/ass13_resp_decoder.sv
// Receive-side decoder and lock-up watchdog for the ass13 controller's 25-bit
// output word: classifies each word, tracks repeated actions, raises sticky alarms.
module ass13_resp_decoder #(
  parameter int unsigned REP_LIMIT = 8,
  parameter int unsigned CW        = 4,
  parameter bit          INV_ALARM = 1'b1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [24:0]   y_in_i,
  input  logic          clr_alarm_i,
  output logic          out_valid_o,
  output logic [3:0]    code_o,
  output logic [4:0]    dest_state_o,
  output logic          invalid_o,
  output logic [CW-1:0] rep_cnt_o,
  output logic          lock_alarm_o,
  output logic          inv_alarm_o,
  output logic [15:0]   word_cnt_o,
  output logic [1:0]    fsm_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ALARM = 2'd2
  } state_e;

  localparam logic [CW-1:0] REP_MAX = '1;
  localparam logic [CW-1:0] REP_LIM = CW'(REP_LIMIT);

  logic          out_valid_q, out_valid_d;
  logic [3:0]    code_q, code_d;
  logic [4:0]    dest_q, dest_d;
  logic          invalid_q, invalid_d;
  logic [CW-1:0] rep_q, rep_d;
  logic [3:0]    prev_q, prev_d;
  logic          lock_q, lock_d;
  logic          inv_q, inv_d;
  logic [15:0]   word_q, word_d;
  state_e        state_q, state_d;

  logic [3:0]    dec_code;
  logic [4:0]    dec_dest;
  logic          dec_bad;
  logic          lock_set;
  logic          inv_set;

  // Exact match on the whole word; anything outside the legal set is invalid.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    dec_code = 4'd0;
    dec_dest = 5'd0;
    dec_bad  = 1'b0;
    case (y_in_i)
      25'h0000000: begin dec_code = 4'd0;  dec_dest = 5'd1;  end
      25'h0000400: begin dec_code = 4'd1;  dec_dest = 5'd2;  end
      25'h000007A: begin dec_code = 4'd2;  dec_dest = 5'd3;  end
      25'h0402078: begin dec_code = 4'd3;  dec_dest = 5'd4;  end
      25'h0010100: begin dec_code = 4'd4;  dec_dest = 5'd0;  end
      25'h000C088: begin dec_code = 4'd5;  dec_dest = 5'd6;  end
      25'h004000E: begin dec_code = 4'd6;  dec_dest = 5'd7;  end
      25'h08000C8: begin dec_code = 4'd7;  dec_dest = 5'd8;  end
      25'h000403A: begin dec_code = 4'd8;  dec_dest = 5'd9;  end
      25'h0000300: begin dec_code = 4'd9;  dec_dest = 5'd10; end
      25'h010200C: begin dec_code = 4'd10; dec_dest = 5'd11; end
      25'h000084A: begin dec_code = 4'd11; dec_dest = 5'd12; end
      25'h0003038: begin dec_code = 4'd12; dec_dest = 5'd13; end
      25'h02A8008: begin dec_code = 4'd13; dec_dest = 5'd14; end
      25'h1020003: begin dec_code = 4'd14; dec_dest = 5'd17; end
      25'h00A000A: begin dec_code = 4'd15; dec_dest = 5'd19; end
      default:     dec_bad = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = in_valid_i;
    code_d      = code_q;
    dest_d      = dest_q;
    invalid_d   = invalid_q;
    rep_d       = rep_q;
    prev_d      = prev_q;
    word_d      = word_q;
    lock_d      = lock_q;
    inv_d       = inv_q;
    state_d     = state_q;
    lock_set    = 1'b0;
    inv_set     = 1'b0;

    if (in_valid_i) begin
      code_d    = dec_code;
      dest_d    = dec_dest;
      invalid_d = dec_bad;
      inv_set   = dec_bad;
      if (word_q != 16'hFFFF) word_d = word_q + 16'd1;

      // Repeat tracking is frozen while the alarm is being serviced.
      if (state_q != S_ALARM) begin
        if (dec_bad) begin
          rep_d  = '0;
          prev_d = 4'd0;
        end else begin
          if (dec_code != 4'd0 && dec_code == prev_q)
            rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + CW'(1);
          else
            rep_d = (dec_code != 4'd0) ? CW'(1) : '0;
          prev_d   = dec_code;
          lock_set = (rep_d == REP_LIM);
          if (state_q == S_IDLE) state_d = S_TRACK;
        end
      end
    end

    if (lock_set) lock_d = 1'b1;
    if (inv_set)  inv_d  = 1'b1;

    // A clear never swallows an alarm raised in the same cycle.
    if (clr_alarm_i) begin
      lock_d  = lock_set;
      inv_d   = inv_set;
      rep_d   = '0;
      prev_d  = 4'd0;
      word_d  = 16'd0;
      state_d = S_IDLE;
    end
    if (lock_set || (inv_set && INV_ALARM)) state_d = S_ALARM;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_i) begin
      out_valid_q <= 1'b0;
      code_q      <= 4'd0;
      dest_q      <= 5'd0;
      invalid_q   <= 1'b0;
      rep_q       <= '0;
      prev_q      <= 4'd0;
      lock_q      <= 1'b0;
      inv_q       <= 1'b0;
      word_q      <= 16'd0;
      state_q     <= S_IDLE;
    end else begin
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      dest_q      <= dest_d;
      invalid_q   <= invalid_d;
      rep_q       <= rep_d;
      prev_q      <= prev_d;
      lock_q      <= lock_d;
      inv_q       <= inv_d;
      word_q      <= word_d;
      state_q     <= state_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign code_o       = code_q;
  assign dest_state_o = dest_q;
  assign invalid_o    = invalid_q;
  assign rep_cnt_o    = rep_q;
  assign lock_alarm_o = lock_q;
  assign inv_alarm_o  = inv_q;
  assign word_cnt_o   = word_q;
  assign fsm_state_o  = state_q;

endmodule

// File: tb/tb_ass13_resp_decoder.sv
// Scoreboard bench for ass13_resp_decoder: two instances (INV_ALARM=0/1) share
// stimulus; a reference model queues expected outputs, a monitor compares them.
module tb_ass13_resp_decoder;

  localparam int REP_LIMIT = 8;

  typedef struct packed {
    logic        ov;
    logic [3:0]  code;
    logic [4:0]  dest;
    logic        bad;
    logic [3:0]  rep;
    logic        la;
    logic        ia;
    logic [15:0] wc;
    logic [1:0]  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [24:0] y_in = '0;
  logic        clr_alarm = 1'b0;

  logic        ov0, ov1, bad0, bad1, la0, la1, ia0, ia1;
  logic [3:0]  code0, code1, rep0, rep1;
  logic [4:0]  dest0, dest1;
  logic [15:0] wc0, wc1;
  logic [1:0]  st0, st1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  ass13_resp_decoder #(.REP_LIMIT(REP_LIMIT), .CW(4), .INV_ALARM(1'b0)) dut0 (
    .clk(clk), .rst_i(rst), .in_valid_i(in_valid), .y_in_i(y_in), .clr_alarm_i(clr_alarm),
    .out_valid_o(ov0), .code_o(code0), .dest_state_o(dest0), .invalid_o(bad0),
    .rep_cnt_o(rep0), .lock_alarm_o(la0), .inv_alarm_o(ia0), .word_cnt_o(wc0),
    .fsm_state_o(st0)
  );

  ass13_resp_decoder #(.REP_LIMIT(REP_LIMIT), .CW(4), .INV_ALARM(1'b1)) dut1 (
    .clk(clk), .rst_i(rst), .in_valid_i(in_valid), .y_in_i(y_in), .clr_alarm_i(clr_alarm),
    .out_valid_o(ov1), .code_o(code1), .dest_state_o(dest1), .invalid_o(bad1),
    .rep_cnt_o(rep1), .lock_alarm_o(la1), .inv_alarm_o(ia1), .word_cnt_o(wc1),
    .fsm_state_o(st1)
  );

  // Legal words as lists of asserted outputs yN (0 = unused slot), and their destinations.
  int pos [16][6] = '{
    '{0, 0, 0, 0, 0, 0},
    '{11, 0, 0, 0, 0, 0},
    '{2, 4, 5, 6, 7, 0},
    '{4, 5, 6, 7, 14, 23},
    '{9, 17, 0, 0, 0, 0},
    '{4, 8, 15, 16, 0, 0},
    '{2, 3, 4, 19, 0, 0},
    '{4, 7, 8, 24, 0, 0},
    '{2, 4, 5, 6, 15, 0},
    '{9, 10, 0, 0, 0, 0},
    '{3, 4, 14, 21, 0, 0},
    '{2, 4, 7, 12, 0, 0},
    '{4, 5, 6, 13, 14, 0},
    '{4, 16, 18, 20, 22, 0},
    '{1, 2, 18, 25, 0, 0},
    '{2, 4, 18, 20, 0, 0}
  };
  int dest_tab [16] = '{1, 2, 3, 4, 0, 6, 7, 8, 9, 10, 11, 12, 13, 14, 17, 19};

  // Reference model state, one slot per instance (index = INV_ALARM value).
  int  m_prev[2], m_rep[2], m_word[2], m_st[2], m_code[2], m_dest[2];
  bit  m_lock[2], m_inv[2], m_bad[2], m_ov[2];

  function automatic logic [24:0] word_of(input int k);
    logic [24:0] w = '0;
    for (int j = 0; j < 6; j++)
      if (pos[k][j] != 0) w[pos[k][j]-1] = 1'b1;
    return w;
  endfunction

  task automatic decode(input logic [24:0] y, output int c, output int d, output bit bad);
    c = 0; d = 0; bad = 1'b1;
    for (int k = 0; k < 16; k++)
      if (y == word_of(k)) begin
        c = k; d = dest_tab[k]; bad = 1'b0;
      end
  endtask

  task automatic model_step(input int k, input bit r, input bit v, input logic [24:0] y,
                            input bit c);
    int dc, dd;
    bit bad, lset, iset;
    lset = 1'b0;
    iset = 1'b0;
    if (r) begin
      m_prev[k] = 0; m_rep[k] = 0; m_word[k] = 0; m_st[k] = 0;
      m_lock[k] = 0; m_inv[k] = 0; m_code[k] = 0; m_dest[k] = 0;
      m_bad[k] = 0;  m_ov[k] = 0;
    end else begin
      m_ov[k] = v;
      if (v) begin
        decode(y, dc, dd, bad);
        m_code[k] = dc; m_dest[k] = dd; m_bad[k] = bad;
        if (m_word[k] < 65535) m_word[k] = m_word[k] + 1;
        iset = bad;
        if (m_st[k] != 2) begin
          if (bad) begin
            m_rep[k] = 0; m_prev[k] = 0;
          end else begin
            if (dc != 0 && dc == m_prev[k]) m_rep[k] = (m_rep[k] < 15) ? m_rep[k] + 1 : 15;
            else m_rep[k] = (dc != 0) ? 1 : 0;
            m_prev[k] = dc;
            lset = (m_rep[k] == REP_LIMIT);
            if (m_st[k] == 0) m_st[k] = 1;
          end
        end
      end
      if (lset) m_lock[k] = 1'b1;
      if (iset) m_inv[k] = 1'b1;
      if (c) begin
        m_lock[k] = lset; m_inv[k] = iset;
        m_rep[k] = 0; m_prev[k] = 0; m_word[k] = 0; m_st[k] = 0;
      end
      if (lset || (iset && k == 1)) m_st[k] = 2;
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.ov = m_ov[k];          e.code = 4'(m_code[k]); e.dest = 5'(m_dest[k]);
    e.bad = m_bad[k];        e.rep = 4'(m_rep[k]);   e.la = m_lock[k];
    e.ia = m_inv[k];         e.wc = 16'(m_word[k]);  e.st = 2'(m_st[k]);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input string id, input exp_t e, input exp_t a);
    check({id, ".out_valid"},  32'(a.ov),   32'(e.ov));
    check({id, ".code"},       32'(a.code), 32'(e.code));
    check({id, ".dest_state"}, 32'(a.dest), 32'(e.dest));
    check({id, ".invalid"},    32'(a.bad),  32'(e.bad));
    check({id, ".rep_cnt"},    32'(a.rep),  32'(e.rep));
    check({id, ".lock_alarm"}, 32'(a.la),   32'(e.la));
    check({id, ".inv_alarm"},  32'(a.ia),   32'(e.ia));
    check({id, ".word_cnt"},   32'(a.wc),   32'(e.wc));
    check({id, ".fsm_state"},  32'(a.st),   32'(e.st));
  endtask

  // Drive one cycle of stimulus and queue what each instance must show after the edge.
  task automatic cyc(input bit r, input bit v, input logic [24:0] y, input bit c);
    @(negedge clk);
    rst = r; in_valid = v; y_in = y; clr_alarm = c;
    for (int k = 0; k < 2; k++) model_step(k, r, v, y, c);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = '{ov0, code0, dest0, bad0, rep0, la0, ia0, wc0, st0};
        compare("inv0", e, a);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '{ov1, code1, dest1, bad1, rep1, la1, ia1, wc1, st1};
        compare("inv1", e, a);
      end
    end
  end

  initial begin
    int lc;
    int r;
    logic [31:0] rnd;
    logic [24:0] y;

    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    // y11 alone after reset.
    cyc(0, 1, word_of(1), 0);
    cyc(0, 0, '0, 0);
    // One word then a run of 9 identical words: lock on the 8th, frozen on the 9th.
    cyc(0, 0, '0, 1);
    cyc(0, 1, word_of(11), 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, word_of(6), 0);
    cyc(0, 0, '0, 1);
    // D,D,D then E: ambiguous destination, no alarm.
    for (int i = 0; i < 3; i++) cyc(0, 1, word_of(4), 0);
    cyc(0, 1, word_of(5), 0);
    // Illegal word {y1,y2}.
    cyc(0, 1, 25'h0000003, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    // Clear coincident with the lock-raising word.
    for (int i = 0; i < 7; i++) cyc(0, 1, word_of(6), 0);
    cyc(0, 1, word_of(6), 1);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    // Gap does not break a run; reset does.
    cyc(0, 1, word_of(1), 0);
    cyc(0, 0, '0, 0);
    cyc(0, 1, word_of(1), 0);
    cyc(1, 0, '0, 0);
    cyc(0, 1, word_of(1), 0);
    cyc(0, 1, word_of(0), 0);
    cyc(0, 1, word_of(0), 0);

    lc = 3;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) y = word_of(lc);
      else if (r < 90) begin
        lc = $urandom_range(0, 15);
        y = word_of(lc);
      end else if (r < 97) begin
        rnd = $urandom();
        y = rnd[24:0];
      end else y = 25'h0000003;
      cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
          y,
          ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
    end

    cyc(0, 0, '0, 0);
    for (int i = 0; i < 10 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
